// File: rtl/rat_intc.sv
// Interrupt controller in front of the RAT control unit. It handles NUM_SRC edge or level
// sources with per-source masking and lowest-index-first priority, and is programmed over the I/O bus.
//   state   | meaning
//   IDLE    | no request outstanding, arbitrate eligible sources
//   REQ     | INTV asserted for ACTIVE_ID, waiting for INT_ACK
//   SERVICE | ISR running for ACTIVE_ID, waiting for EOI write
module rat_intc #(
    parameter int         NUM_SRC    = 8,
    parameter logic [7:0] LEVEL_MASK = 8'h00,
    parameter logic [7:0] MASK_PORT  = 8'h20,
    parameter logic [7:0] PEND_PORT  = 8'h21,
    parameter logic [7:0] VEC_PORT   = 8'h22
) (
    input  logic               clk,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    input  logic               INT_ACK,
    output logic               INTV,
    output logic [2:0]         ACTIVE_ID,
    output logic [7:0]         IN_DATA,
    output logic               IN_SEL
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q;
    logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d;
    logic [NUM_SRC-1:0] rise, w1c, ack_clr;
    logic [2:0]         active_id_q, active_id_d, winner;
    logic [7:0]         pend8, mask8, elig8;
    logic               mask_wr, pend_wr, eoi, active_elig, in_service;

    assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
    assign pend_wr = IO_STRB && (PORT_ID == PEND_PORT);
    assign eoi     = IO_STRB && (PORT_ID == VEC_PORT);

    assign rise   = sync2_q & ~hist_q;
    assign w1c    = pend_wr ? OUT_PORT[NUM_SRC-1:0] : '0;
    assign mask_d = mask_wr ? OUT_PORT[NUM_SRC-1:0] : mask_q;

    // Zero-extended views let the rest of the logic work on fixed 8-bit vectors
    always_comb begin
        pend8 = '0;
        mask8 = '0;
        pend8[NUM_SRC-1:0] = pend_q;
        mask8[NUM_SRC-1:0] = mask_q;
    end

    assign elig8       = pend8 & mask8;
    assign active_elig = elig8[active_id_q];

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig8[i]) winner = 3'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = INT_ACK && (state_q == REQ) && (active_id_q == 3'(i));
        end
    end

    // Edge bits: a new edge overrides a coincident ACK or W1C clear
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (LEVEL_MASK[i]) pend_d[i] = sync2_q[i];
            else               pend_d[i] = rise[i] | (pend_q[i] & ~w1c[i] & ~ack_clr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
        end else begin
            sync1_q <= IRQ_IN;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            active_id_q <= '0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        case (state_q)
            IDLE: begin
                if (|elig8) begin
                    state_d     = REQ;
                    active_id_d = winner;
                end
            end
            REQ: begin
                if (INT_ACK)           state_d = SERVICE;
                else if (!active_elig) state_d = IDLE;
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        INTV       = (state_q == REQ);
        in_service = (state_q == SERVICE);
    end

    assign ACTIVE_ID = active_id_q;

    always_comb begin
        IN_DATA = '0;
        IN_SEL  = 1'b0;
        if (PORT_ID == MASK_PORT) begin
            IN_DATA = mask8;
            IN_SEL  = 1'b1;
        end else if (PORT_ID == PEND_PORT) begin
            IN_DATA = pend8;
            IN_SEL  = 1'b1;
        end else if (PORT_ID == VEC_PORT) begin
            IN_DATA = {in_service, 4'b0000, active_id_q};
            IN_SEL  = 1'b1;
        end
    end

endmodule

// File: tb/tb_rat_intc.sv
// Bench for rat_intc: directed scenarios plus random traffic, all compared against a
// sample-history reference model of the controller.
module tb_rat_intc;

    localparam logic [7:0] MP  = 8'h20;
    localparam logic [7:0] PP  = 8'h21;
    localparam logic [7:0] VP  = 8'h22;
    localparam logic [7:0] LVL = 8'h01;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SERV = 2;

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] IRQ_IN = '0;
    logic [7:0] PORT_ID = '0;
    logic [7:0] OUT_PORT = '0;
    logic       IO_STRB = 1'b0;
    logic       INT_ACK = 1'b0;
    logic       INTV;
    logic [2:0] ACTIVE_ID;
    logic [7:0] IN_DATA;
    logic       IN_SEL;

    always #5 clk = ~clk;

    rat_intc #(
        .NUM_SRC   (8),
        .LEVEL_MASK(LVL),
        .MASK_PORT (MP),
        .PEND_PORT (PP),
        .VEC_PORT  (VP)
    ) dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .IRQ_IN   (IRQ_IN),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .INT_ACK  (INT_ACK),
        .INTV     (INTV),
        .ACTIVE_ID(ACTIVE_ID),
        .IN_DATA  (IN_DATA),
        .IN_SEL   (IN_SEL)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: IRQ samples taken at the last three edges, newest first
    logic [7:0] smp0 = '0, smp1 = '0, smp2 = '0;
    logic [7:0] m_mask = '0, m_pend = '0;
    logic [2:0] m_id = '0;
    int         m_mode = M_IDLE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] p);
        if (p == MP) return m_mask;
        if (p == PP) return m_pend;
        if (p == VP) return {(m_mode == M_SERV), 4'b0000, m_id};
        return 8'h00;
    endfunction

    task automatic model_step();
        logic [7:0] elig, npend, lvl;
        int         nmode;
        logic [2:0] nid;
        bit         found;
        lvl = LVL;
        if (!RESET_N) begin
            smp0 = '0; smp1 = '0; smp2 = '0;
            m_mask = '0; m_pend = '0; m_id = '0; m_mode = M_IDLE;
            return;
        end
        elig  = m_pend & m_mask;
        npend = m_pend;
        for (int i = 0; i < 8; i++) begin
            if (lvl[i]) begin
                npend[i] = smp1[i];
            end else begin
                if (IO_STRB && PORT_ID == PP && OUT_PORT[i]) npend[i] = 1'b0;
                if (INT_ACK && m_mode == M_REQ && int'(m_id) == i) npend[i] = 1'b0;
                if (smp1[i] && !smp2[i]) npend[i] = 1'b1;
            end
        end
        nmode = m_mode;
        nid   = m_id;
        found = 0;
        if (m_mode == M_IDLE) begin
            for (int i = 0; i < 8; i++) begin
                if (!found && elig[i]) begin
                    found = 1;
                    nid   = 3'(i);
                    nmode = M_REQ;
                end
            end
        end else if (m_mode == M_REQ) begin
            if (INT_ACK)            nmode = M_SERV;
            else if (!elig[m_id])   nmode = M_IDLE;
        end else begin
            if (IO_STRB && PORT_ID == VP) nmode = M_IDLE;
        end
        if (IO_STRB && PORT_ID == MP) m_mask = OUT_PORT;
        m_pend = npend;
        m_mode = nmode;
        m_id   = nid;
        smp2 = smp1;
        smp1 = smp0;
        smp0 = IRQ_IN;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("intv", INTV, m_mode == M_REQ);
        check("active_id", ACTIVE_ID, m_id);
        check("in_data", IN_DATA, exp_rd(PORT_ID));
        check("in_sel", IN_SEL, (PORT_ID == MP) || (PORT_ID == PP) || (PORT_ID == VP));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic io_write(input logic [7:0] p, input logic [7:0] d);
        PORT_ID  = p;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
        OUT_PORT = '0;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
        PORT_ID = p;
        #1;
        check(tag, IN_DATA, exp);
    endtask

    task automatic wait_intv(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (INTV === 1'b1) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        // Reset
        RESET_N = 1'b0;
        ticks(2);
        RESET_N = 1'b1;
        check("reset_intv", INTV, 0);
        rd("reset_mask", MP, 8'h00);
        rd("reset_pend", PP, 8'h00);
        rd("reset_vec", VP, 8'h00);

        // Single edge source, latency and ACK/EOI
        io_write(MP, 8'h05);
        IRQ_IN = 8'h04;
        ticks(3);
        rd("s1_pend", PP, 8'h04);
        check("s1_intv_e3", INTV, 0);
        IRQ_IN = 8'h00;
        tick();
        check("s1_intv_e4", INTV, 1);
        check("s1_id", ACTIVE_ID, 2);
        ack();
        rd("s1_pend_ack", PP, 8'h00);
        rd("s1_vec_srv", VP, 8'h82);
        io_write(VP, 8'hFF);
        rd("s1_vec_eoi", VP, 8'h02);
        ticks(2);
        check("s1_intv_quiet", INTV, 0);

        // Simultaneous edges, lowest index wins then the other is served
        io_write(MP, 8'hFF);
        IRQ_IN = 8'h22;
        wait_intv("s2_req1", 8);
        check("s2_id1", ACTIVE_ID, 1);
        ack();
        io_write(VP, 8'h00);
        tick();
        check("s2_intv2", INTV, 1);
        check("s2_id5", ACTIVE_ID, 5);
        ack();
        io_write(VP, 8'h00);
        rd("s2_pend", PP, 8'h00);
        IRQ_IN = 8'h00;
        ticks(3);

        // Masked pending, unmask, then withdraw with W1C
        io_write(MP, 8'h00);
        IRQ_IN = 8'h08;
        ticks(4);
        IRQ_IN = 8'h00;
        rd("s3_pend", PP, 8'h08);
        check("s3_intv_masked", INTV, 0);
        io_write(MP, 8'h08);
        check("s3_intv_e1", INTV, 0);
        tick();
        check("s3_intv_e2", INTV, 1);
        check("s3_id", ACTIVE_ID, 3);
        io_write(PP, 8'h08);
        tick();
        check("s3_withdraw", INTV, 0);
        rd("s3_vec", VP, 8'h03);
        rd("s3_pend0", PP, 8'h00);

        // Level source 0
        io_write(MP, 8'h01);
        IRQ_IN = 8'h01;
        wait_intv("s4_req", 8);
        check("s4_id", ACTIVE_ID, 0);
        ack();
        io_write(VP, 8'h00);
        tick();
        check("s4_reassert", INTV, 1);
        ack();
        IRQ_IN = 8'h00;
        ticks(3);
        io_write(VP, 8'h00);
        ticks(2);
        check("s4_quiet", INTV, 0);

        // Edge coincident with W1C: set wins
        io_write(MP, 8'h00);
        IRQ_IN = 8'h10;
        ticks(2);
        io_write(PP, 8'h10);
        rd("s5_pend", PP, 8'h10);
        IRQ_IN = 8'h00;

        // Reset while in SERVICE
        io_write(MP, 8'h10);
        tick();
        check("s6_req", INTV, 1);
        ack();
        rd("s6_vec_srv", VP, 8'h84);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check("s6_intv", INTV, 0);
        rd("s6_mask", MP, 8'h00);
        rd("s6_pend", PP, 8'h00);
        rd("s6_vec", VP, 8'h00);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 20) IRQ_IN = IRQ_IN ^ (8'h01 << $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       PORT_ID = MP;
                1:       PORT_ID = PP;
                2:       PORT_ID = VP;
                default: PORT_ID = 8'($urandom);
            endcase
            IO_STRB  = ($urandom_range(0, 7) == 0);
            OUT_PORT = 8'($urandom);
            INT_ACK  = (m_mode == M_REQ) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            RESET_N  = ($urandom_range(0, 499) != 0);
            tick();
        end
        IO_STRB = 1'b0;
        INT_ACK = 1'b0;
        RESET_N = 1'b1;
        IRQ_IN  = '0;
        ticks(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
